// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage load-use/RAW/WAW/structural stall generation and multi-cycle scoreboard.
// Define HZ_STALL_CNT_EN to enable stall_count; otherwise the port is tied to 0.
module hazard_scoreboard #(
   parameter int MC_DEPTH      = 2,
   parameter int STALL_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  id_rd,
   input  logic        id_regwrite,
   input  logic        id_is_mc,
   input  logic        ID_EX_memread,
   input  logic [4:0]  RD_ID_EX,
   input  logic        flush,
   input  logic        mc_done,
   input  logic [4:0]  mc_done_rd,
   output logic        stall,
   output logic        bubble,
   output logic [31:0] pending,
   output logic [2:0]  mc_outstanding,
   output logic        sb_err,
   output logic        sb_timeout,
   output logic [31:0] stall_count
);
   logic [31:0] pending_q, pending_d;
   logic [2:0]  mc_out_q, mc_out_d;
   logic        sb_err_q, sb_err_d;
   logic        sb_to_q, sb_to_d;
   logic [31:0] run_q, run_d;
   logic        id_ok, load_use, raw, waw, structural, issue, retire_bad, retire;

   always_comb begin
      id_ok      = id_valid & ~flush;
      load_use   = ID_EX_memread && RD_ID_EX != 5'd0 &&
                   ((id_rs1_used && id_rs1 == RD_ID_EX) || (id_rs2_used && id_rs2 == RD_ID_EX));
      raw        = (id_rs1_used && id_rs1 != 5'd0 && pending_q[id_rs1]) ||
                   (id_rs2_used && id_rs2 != 5'd0 && pending_q[id_rs2]);
      waw        = id_regwrite && id_rd != 5'd0 && pending_q[id_rd];
      structural = id_is_mc && mc_out_q == 3'(MC_DEPTH);
      stall      = id_ok & (load_use | raw | waw | structural);
      bubble     = stall;
      issue      = id_ok & ~stall & id_is_mc;
      // A bad retire is flagged and otherwise ignored so the count never wraps
      retire_bad = mc_done && (mc_out_q == 3'd0 || (mc_done_rd != 5'd0 && !pending_q[mc_done_rd]));
      retire     = mc_done & ~retire_bad;
      pending_d  = pending_q;
      if (retire) pending_d[mc_done_rd] = 1'b0;
      if (issue && id_regwrite && id_rd != 5'd0) pending_d[id_rd] = 1'b1;
      pending_d[0] = 1'b0;
      mc_out_d   = mc_out_q + {2'b0, issue} - {2'b0, retire};
      sb_err_d   = sb_err_q | retire_bad;
      run_d      = !stall ? 32'd0 : (run_q == 32'(STALL_TIMEOUT) ? run_q : run_q + 32'd1);
      sb_to_d    = sb_to_q | (run_d == 32'(STALL_TIMEOUT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         mc_out_q  <= '0;
         sb_err_q  <= 1'b0;
         sb_to_q   <= 1'b0;
         run_q     <= '0;
      end else begin
         pending_q <= pending_d;
         mc_out_q  <= mc_out_d;
         sb_err_q  <= sb_err_d;
         sb_to_q   <= sb_to_d;
         run_q     <= run_d;
      end
   end

`ifdef HZ_STALL_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb cnt_d = (stall && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign stall_count = cnt_q;
`else
   assign stall_count = '0;
`endif

   assign pending        = pending_q;
   assign mc_outstanding = mc_out_q;
   assign sb_err         = sb_err_q;
   assign sb_timeout     = sb_to_q;
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Hazard and scoreboard control block for the 5-stage RV32 pipeline. It sits at the ID stage and produces the stalls that `forwarding_unit` cannot resolve by bypassing: load-use hazards, RAW/WAW hazards on multi-cycle (mul/div) destinations, and multi-cycle structural limits. It tracks in-flight multi-cycle producers in a pending-register scoreboard, and retires them when the multi-cycle unit reports completion.

## Interface
- `MC_DEPTH`, default 2: maximum outstanding multi-cycle ops (1..7).
- `STALL_TIMEOUT`, default 64: consecutive stall cycles before the watchdog flag sets.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `id_valid` input 1: valid instruction in IF/ID.
- `id_rs1`, `id_rs2` input 5 each: ID source register numbers.
- `id_rs1_used`, `id_rs2_used` input 1 each: the source is actually read.
- `id_rd` input 5: ID destination register.
- `id_regwrite` input 1: the ID instruction writes `id_rd`.
- `id_is_mc` input 1: the ID instruction is multi-cycle (mul/div).
- `ID_EX_memread` input 1: the instruction in EX is a load.
- `RD_ID_EX` input 5: destination of the instruction in EX.
- `flush` input 1: branch/jump redirect; squashes the IF/ID instruction.
- `mc_done` input 1: one-cycle pulse; the multi-cycle unit wrote back.
- `mc_done_rd` input 5: register retired by `mc_done`.
- `stall` output 1: hold PC and IF/ID.
- `bubble` output 1: zero the ID/EX control fields.
- `pending` output 32: scoreboard vector, registered. Bit 0 is always 0.
- `mc_outstanding` output 3: count of in-flight multi-cycle ops, registered.
- `sb_err` output 1: sticky flag for a retire of a non-pending register.
- `sb_timeout` output 1: sticky stall watchdog flag.
- `stall_count` output 32: stall cycle counter (see Configuration).

## Operation
Hazard terms are combinational from inputs and registered state. All terms are gated by `id_valid & ~flush`.
- **Load-use:** `ID_EX_memread`, `RD_ID_EX != 0`, and (`id_rs1_used` with `id_rs1 == RD_ID_EX`, or `id_rs2_used` with `id_rs2 == RD_ID_EX`).
- **RAW:** a used source `rsN != 0` has `pending[rsN] == 1`.
- **WAW:** `id_regwrite`, `id_rd != 0`, and `pending[id_rd] == 1`.
- **Structural:** `id_is_mc` and `mc_outstanding == MC_DEPTH`.
- **Outputs:** `stall = bubble = ` OR of the four terms.

Issue and retire:
- **Issue** happens when `id_valid & ~flush & ~stall & id_is_mc`:
  - If `id_regwrite` and `id_rd != 0`, set `pending[id_rd]`.
  - Increment `mc_outstanding` regardless of destination.
- **Retire** on `mc_done`:
  - Clear `pending[mc_done_rd]` and decrement `mc_outstanding`.
  - If `mc_outstanding == 0`, or `mc_done_rd != 0` with its pending bit clear: set `sb_err`, leave state unchanged, and do not wrap the counter.
- **Issue and retire in the same cycle:** the count is unchanged and set/clear both apply. The same register cannot be both set and cleared, because WAW blocks it.
- **Flush:** squashes only the ID instruction. Pending bits and the count are unaffected; in-flight ops still retire.

Watchdog:
- A stall-run counter increments while `stall` is high and clears when it is low.
- When the counter reaches `STALL_TIMEOUT`, `sb_timeout` sets (sticky) and the counter saturates.

## Timing
- `stall`/`bubble` are asserted in the same cycle as the hazard (zero latency).
- Load-use stall lasts exactly one cycle. Next cycle the load is in MEM and `forwarding_unit` handles it.
- Scoreboard updates are visible the cycle after the edge. A register retired by `mc_done` in cycle N still stalls readers in cycle N; the stall releases in N+1, when the value is in the register file.
- An issue in cycle N makes `pending[id_rd]` visible in N+1.
- Reset (asynchronous, any time, including mid-stall or with ops in flight):
  - `pending = 0`, `mc_outstanding = 0`, `sb_err = 0`, `sb_timeout = 0`, `stall_count = 0`, run counter `= 0`.
  - `stall`/`bubble` follow their inputs combinationally; with `id_valid` low they are 0.
- `mc_done` is sampled only on clock edges with `rst_n` high.

## Configuration
- `HZ_STALL_CNT_EN` defined: `stall_count` increments on every cycle with `stall` high, saturates at 0xFFFF_FFFF, and clears on reset.
- Undefined: counter logic is removed and `stall_count` is tied to 0. The port remains.

## Test plan
- **Load-use:** `ID_EX_memread=1`, `RD_ID_EX=5`, `id_rs2=5` used → `stall=1` for 1 cycle, then 0. With `RD_ID_EX=0` → `stall=0`.
- **Multi-cycle RAW:**
  - Issue a div with `id_rd=7`, then a dependent `id_rs1=7`.
  - Required: `pending[7]=1`, stall held until `mc_done` with `mc_done_rd=7` in cycle N, stall released in N+1, `pending[7]=0`.
- **Structural limit (`MC_DEPTH=2`):** issue mc ops to x3 and x4, then a third mc op → stall. A `mc_done` (x3) releases it one cycle later; `mc_outstanding` goes 2→1→2.
- **Flush:** with `flush=1` during an mc issue, no pending bit is set and `mc_outstanding` is unchanged. A spurious `mc_done` with `mc_outstanding=0` → `sb_err=1`, count stays 0.
- **Reset and watchdog:**
  - Assert `rst_n=0` mid-stall with 2 ops outstanding → all state 0 immediately.
  - Hold a RAW stall for 64 cycles → `sb_timeout=1`. With `HZ_STALL_CNT_EN`, `stall_count=64`.
